wb_ctrl: RTL and testbench

- Single-entry writeback-stage controller between EX and the register-file write port.
- Accepts one instruction per handshake from EX and holds it in a WB slot.
- Loads and stores wait in the slot for the LSU response; all other instructions write immediately.
- Arbitrates the single RF write port between the EX result and LSU load data, and generates retire and perf pulses, LSU error pulses and LSU timeout pulses.

---
 rtl/ibex_pkg.sv | 34 +++
 rtl/wb_ctrl.sv | 144 ++++++++++++++
 tb/tb_wb_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the writeback-stage controller.
//   wb_instr_type_e : instruction class presented by EX (LOAD, STORE, OTHER)
//   wb_ctrl_state_e : WB slot occupancy state
//   wb_slot_t       : fields captured from EX when an instruction enters WB
package ibex_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_HOLD,
        WB_WAIT_LSU
    } wb_ctrl_state_e;

    typedef struct packed {
        wb_instr_type_e instr_type;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        logic           we;
        logic [31:0]    pc;
        logic           compressed;
        logic           perf;
    } wb_slot_t;

    // Loads and stores park in the slot until the LSU answers.
    function automatic logic is_mem(wb_instr_type_e t);
        return (t == WB_INSTR_LOAD) || (t == WB_INSTR_STORE);
    endfunction

endpackage

// File: rtl/wb_ctrl.sv
// wb_ctrl: single-entry writeback slot between EX and the register-file
// write port.
//   clk_i, rst_ni                     clock, async active-low reset
//   flush_i                           kill the slot (exception/branch)
//   en_wb_i, instr_type_wb_i, rf_*_ex_i, pc_ex_i,
//   instr_is_compressed_i, instr_perf_count_i
//                                     instruction offered by EX
//   ready_wb_o                        slot can take an instruction now
//   lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i
//                                     LSU response for a parked load/store
//   rf_we_o, rf_waddr_o, rf_wdata_o, rf_wdata_sel_o
//                                     RF write port (sel: 0 = EX, 1 = LSU)
//   pc_wb_o, outstanding_o            slot PC, slot waiting on LSU
//   perf_instr_ret_o, perf_instr_ret_compressed_o
//                                     retire pulses
//   lsu_err_o, lsu_timeout_o          LSU error / abandonment pulses
module wb_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned LsuTimeout = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        en_wb_i,
    input  logic [1:0]  instr_type_wb_i,
    input  logic [4:0]  rf_waddr_ex_i,
    input  logic [31:0] rf_wdata_ex_i,
    input  logic        rf_we_ex_i,
    input  logic [31:0] pc_ex_i,
    input  logic        instr_is_compressed_i,
    input  logic        instr_perf_count_i,
    output logic        ready_wb_o,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] rf_wdata_lsu_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_wdata_sel_o,
    output logic [31:0] pc_wb_o,
    output logic        outstanding_o,
    output logic        perf_instr_ret_o,
    output logic        perf_instr_ret_compressed_o,
    output logic        lsu_err_o,
    output logic        lsu_timeout_o
);

    localparam int unsigned CntW = $clog2(LsuTimeout + 1);

    wb_ctrl_state_e state_q, state_d;
    wb_slot_t       slot_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    wb_instr_type_e new_type;
    logic           in_hold, in_wait, timeout_hit, done, accept;

    assign new_type = wb_instr_type_e'(instr_type_wb_i);

    // Address and PC are not qualified; rf_we_o is the only valid strobe.
    assign rf_waddr_o    = slot_q.waddr;
    assign pc_wb_o       = slot_q.pc;
    assign outstanding_o = in_wait;

    // NOTE: every signal driven here gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    always_comb begin
        rf_we_o                     = 1'b0;
        rf_wdata_o                  = '0;
        rf_wdata_sel_o              = 1'b0;
        perf_instr_ret_o            = 1'b0;
        lsu_err_o                   = 1'b0;
        lsu_timeout_o               = 1'b0;
        state_d                     = state_q;

        in_hold     = (state_q == WB_HOLD);
        in_wait     = (state_q == WB_WAIT_LSU);
        timeout_hit = in_wait && (cnt_q == CntW'(LsuTimeout - 1));
        done        = in_hold || (in_wait && (lsu_resp_valid_i || timeout_hit));
        ready_wb_o  = !flush_i && ((state_q == WB_IDLE) || done);
        accept      = en_wb_i && ready_wb_o;

        // A flush suppresses every side effect of the draining instruction.
        if (!flush_i) begin
            if (in_hold) begin
                rf_we_o          = slot_q.we;
                rf_wdata_o       = slot_q.we ? slot_q.wdata : '0;
                perf_instr_ret_o = slot_q.perf;
            end else if (in_wait && lsu_resp_valid_i) begin
                // A response in the timeout cycle wins over the timeout.
                if (lsu_resp_err_i) begin
                    lsu_err_o = 1'b1;
                end else begin
                    perf_instr_ret_o = slot_q.perf;
                    if (slot_q.instr_type == WB_INSTR_LOAD) begin
                        rf_we_o        = slot_q.we;
                        rf_wdata_o     = slot_q.we ? rf_wdata_lsu_i : '0;
                        rf_wdata_sel_o = 1'b1;
                    end
                end
            end else if (timeout_hit) begin
                lsu_timeout_o = 1'b1;
            end
        end
        perf_instr_ret_compressed_o = perf_instr_ret_o && slot_q.compressed;

        if (flush_i) begin
            state_d = WB_IDLE;
        end else if (accept) begin
            state_d = is_mem(new_type) ? WB_WAIT_LSU : WB_HOLD;
        end else if (done) begin
            state_d = WB_IDLE;
        end

        // Counts only while the same instruction keeps waiting; any exit
        // (including drain-and-refill with another load) restarts at zero.
        cnt_d = (in_wait && !done && !flush_i) ? cnt_q + 1'b1 : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the slot registers are reset too, so rf_waddr_o and pc_wb_o come
    // out of reset as zero rather than X.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                slot_q.instr_type <= new_type;
                slot_q.waddr      <= rf_waddr_ex_i;
                slot_q.wdata      <= rf_wdata_ex_i;
                slot_q.we         <= rf_we_ex_i;
                slot_q.pc         <= pc_ex_i;
                slot_q.compressed <= instr_is_compressed_i;
                slot_q.perf       <= instr_perf_count_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: scoreboard bench for wb_ctrl. A slot-level reference model
// predicts each cycle's RF write / retire / error / timeout event and queues
// it; a monitor process pops and compares whenever the DUT shows one.
module tb_wb_ctrl;
    import ibex_pkg::*;

    localparam int TMO = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        sel;
        logic        ret;
        logic        retc;
        logic        err;
        logic        tmo;
        logic [31:0] pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, en, we, comp, perf, resp, err;
    logic [1:0]  typ;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc, lsu_data;

    logic        ready, rf_we, rf_sel, outstanding, ret, retc, lsu_err, lsu_tmo;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pc_wb;

    int n_tests = 0;
    int n_fail  = 0;
    ev_t exp_q[$];

    // Reference model: one optional instruction plus how long it has waited.
    logic        m_valid, m_we, m_comp, m_perf, m_done, m_ready;
    logic [1:0]  m_typ;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc;
    int          m_age;

    wb_ctrl #(.LsuTimeout(TMO)) dut (
        .clk_i                       (clk),
        .rst_ni                      (rst_n),
        .flush_i                     (flush),
        .en_wb_i                     (en),
        .instr_type_wb_i             (typ),
        .rf_waddr_ex_i               (waddr),
        .rf_wdata_ex_i               (wdata),
        .rf_we_ex_i                  (we),
        .pc_ex_i                     (pc),
        .instr_is_compressed_i       (comp),
        .instr_perf_count_i          (perf),
        .ready_wb_o                  (ready),
        .lsu_resp_valid_i            (resp),
        .lsu_resp_err_i              (err),
        .rf_wdata_lsu_i              (lsu_data),
        .rf_we_o                     (rf_we),
        .rf_waddr_o                  (rf_waddr),
        .rf_wdata_o                  (rf_wdata),
        .rf_wdata_sel_o              (rf_sel),
        .pc_wb_o                     (pc_wb),
        .outstanding_o               (outstanding),
        .perf_instr_ret_o            (ret),
        .perf_instr_ret_compressed_o (retc),
        .lsu_err_o                   (lsu_err),
        .lsu_timeout_o               (lsu_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_typ = '0; m_waddr = '0; m_wdata = '0; m_we = 1'b0;
        m_pc = '0; m_comp = 1'b0; m_perf = 1'b0; m_age = 0;
        exp_q.delete();
    endtask

    task automatic set_idle();
        flush = 1'b0; en = 1'b0; resp = 1'b0; err = 1'b0;
    endtask

    task automatic offer(logic [1:0] t, logic [4:0] a, logic [31:0] d, logic w,
                         logic c, logic p);
        en = 1'b1; typ = t; waddr = a; wdata = d; we = w; comp = c; perf = p;
        pc = $urandom;
    endtask

    // Predict this cycle's outputs from the current inputs and model slot.
    task automatic eval_cycle();
        ev_t  e;
        logic mem;
        #1;
        mem     = m_valid && (m_typ != WB_INSTR_OTHER);
        m_done  = m_valid && (!mem || resp || m_age == TMO - 1);
        m_ready = !flush && (!m_valid || m_done);
        check("ready", 128'(ready), 128'(m_ready));
        check("outstanding", 128'(outstanding), 128'(mem));
        e = '0;
        e.waddr = m_waddr;
        e.pc    = m_pc;
        if (!flush && m_done) begin
            if (!mem) begin
                e.we = m_we; e.wdata = m_we ? m_wdata : 32'h0; e.ret = m_perf;
            end else if (resp && err) begin
                e.err = 1'b1;
            end else if (resp) begin
                e.ret = m_perf;
                if (m_typ == WB_INSTR_LOAD) begin
                    e.we = m_we; e.sel = 1'b1; e.wdata = m_we ? lsu_data : 32'h0;
                end
            end else begin
                e.tmo = 1'b1;
            end
            e.retc = e.ret && m_comp;
            if (e.we || e.ret || e.err || e.tmo) exp_q.push_back(e);
        end
    endtask

    task automatic model_update();
        if (flush) begin
            m_valid = 1'b0;
        end else if (en && m_ready) begin
            m_valid = 1'b1; m_typ = typ; m_waddr = waddr; m_wdata = wdata;
            m_we = we; m_pc = pc; m_comp = comp; m_perf = perf; m_age = 0;
        end else if (m_done) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_age++;
        end
    endtask

    task automatic step();
        eval_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_outputs",
              {rf_we, rf_waddr, rf_wdata, rf_sel, pc_wb, outstanding, ret, retc, lsu_err, lsu_tmo},
              '0);
    endtask

    // Monitor: pops one expectation per visible event, flags extras/misses.
    initial begin
        ev_t act, e;
        forever begin
            @(negedge clk);
            #3;
            act = '{we: rf_we, waddr: rf_waddr, wdata: rf_wdata, sel: rf_sel, ret: ret,
                    retc: retc, err: lsu_err, tmo: lsu_tmo, pc: pc_wb};
            if (rf_we || ret || lsu_err || lsu_tmo) begin
                if (exp_q.size() == 0) check("spurious_event", 128'(act), '0);
                else begin
                    e = exp_q.pop_front();
                    check("event", 128'(act), 128'(e));
                end
            end else begin
                check("idle_wdata", 128'(rf_wdata), '0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("missing_event", 128'(act), 128'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        typ = WB_INSTR_OTHER; waddr = '0; wdata = '0; we = 1'b0; pc = '0;
        comp = 1'b0; perf = 1'b0; lsu_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // OTHER back-to-back, one per cycle.
        for (int i = 0; i < 3; i++) begin
            offer(WB_INSTR_OTHER, 5'(5 + i), 32'h11 * (i + 1), 1'b1, 1'b0, 1'b1);
            step();
        end
        set_idle(); step();

        // LOAD answered on the fourth wait cycle (also the timeout cycle).
        offer(WB_INSTR_LOAD, 5'd10, 32'h0, 1'b1, 1'b0, 1'b1); step();
        set_idle(); repeat (3) step();
        resp = 1'b1; lsu_data = 32'hDEADBEEF; step();
        set_idle(); step();

        // Compressed STORE with a bus error.
        offer(WB_INSTR_STORE, 5'd3, 32'h0, 1'b0, 1'b1, 1'b1); step();
        set_idle(); step();
        resp = 1'b1; err = 1'b1; step();
        set_idle(); step();

        // LOAD abandoned after TMO wait cycles.
        offer(WB_INSTR_LOAD, 5'd12, 32'h0, 1'b1, 1'b0, 1'b1); step();
        set_idle(); repeat (TMO) step();
        step();

        // LOAD whose response lands exactly in the timeout cycle.
        offer(WB_INSTR_LOAD, 5'd13, 32'h0, 1'b1, 1'b1, 1'b1); step();
        set_idle(); repeat (TMO - 1) step();
        resp = 1'b1; lsu_data = 32'hCAFE0001; step();
        set_idle(); step();

        // Flush while waiting, then a late response and a fresh OTHER.
        offer(WB_INSTR_LOAD, 5'd14, 32'h0, 1'b1, 1'b0, 1'b1); step();
        set_idle(); step();
        flush = 1'b1; step();
        set_idle(); step();
        resp = 1'b1; lsu_data = 32'h12345678; step();
        set_idle();
        offer(WB_INSTR_OTHER, 5'd15, 32'h55AA55AA, 1'b1, 1'b1, 1'b1); step();
        set_idle(); step();

        // Asynchronous reset in the middle of a wait.
        offer(WB_INSTR_LOAD, 5'd16, 32'h0, 1'b1, 1'b0, 1'b1); step();
        set_idle();
        eval_cycle();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp = 1'b1; lsu_data = 32'hBAD0BAD0; step();
        offer(WB_INSTR_LOAD, 5'd17, 32'h0, 1'b1, 1'b0, 1'b1); step();
        set_idle(); step();
        resp = 1'b1; lsu_data = 32'h0BADF00D; step();
        set_idle(); step();

        // Randomized traffic, including spurious responses and flushes.
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 2))
                0:       typ = WB_INSTR_LOAD;
                1:       typ = WB_INSTR_STORE;
                default: typ = WB_INSTR_OTHER;
            endcase
            waddr    = 5'($urandom);
            wdata    = $urandom;
            we       = 1'($urandom);
            pc       = $urandom;
            comp     = 1'($urandom);
            perf     = ($urandom_range(0, 3) != 0);
            resp     = ($urandom_range(0, 99) < 35);
            err      = resp && ($urandom_range(0, 99) < 25);
            lsu_data = $urandom;
            flush    = ($urandom_range(0, 99) < 5);
            step();
        end
        set_idle();
        repeat (TMO + 2) step();

        check("queue_drained", 128'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
